// File: rtl/draw_sprite_if.sv
// VGA stream bundle shared by the background and overlay stages.
// The 'in' modport is for a consumer of the stream and the 'out' modport is for its producer.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// Two-stage sprite overlay: stage 1 tests the box and issues the ROM address,
// stage 2 merges ROM colour over the background. Position updates apply only at vblank start.
module draw_sprite #(
  parameter int          SPRITE_W    = 48,
  parameter int          SPRITE_H    = 64,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  localparam int         ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 vga_in,
  vga_if.out                vga_out,
  input  logic [10:0]       xpos_in,
  input  logic [10:0]       ypos_in,
  input  logic              pos_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data
);

  logic [10:0] pend_x, pend_y;
  logic [10:0] act_x, act_y;
  logic        prev_vblnk;
  logic        vblnk_rise;

  assign vblnk_rise = vga_in.vblnk && !prev_vblnk;

  // A strobe that lands on the vblank edge takes effect immediately instead of waiting a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x     <= '0;
      pend_y     <= '0;
      act_x      <= '0;
      act_y      <= '0;
      prev_vblnk <= 1'b0;
    end else begin
      prev_vblnk <= vga_in.vblnk;
      if (pos_valid) begin
        pend_x <= xpos_in;
        pend_y <= ypos_in;
      end
      if (vblnk_rise) begin
        act_x <= pos_valid ? xpos_in : pend_x;
        act_y <= pos_valid ? ypos_in : pend_y;
      end
    end
  end

  // Box bounds at 12 bits so act + size never wraps past 2047.
  logic [11:0]       h12, v12, x12, y12, dx, dy;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    h12 = {1'b0, vga_in.hcount};
    v12 = {1'b0, vga_in.vcount};
    x12 = {1'b0, act_x};
    y12 = {1'b0, act_y};
    dx  = h12 - x12;
    dy  = v12 - y12;
    in_box = !vga_in.hblnk && !vga_in.vblnk &&
             (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
             (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
    addr_next = '0;
    if (in_box)
      addr_next = ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);
  end

  logic        in_box_d;
  logic [10:0] vcount_d, hcount_d;
  logic        vsync_d, vblnk_d, hsync_d, hblnk_d;
  logic [11:0] rgb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      in_box_d <= 1'b0;
      vcount_d <= '0;
      vsync_d  <= 1'b0;
      vblnk_d  <= 1'b0;
      hcount_d <= '0;
      hsync_d  <= 1'b0;
      hblnk_d  <= 1'b0;
      rgb_d    <= '0;
    end else begin
      rom_addr <= addr_next;
      in_box_d <= in_box;
      vcount_d <= vga_in.vcount;
      vsync_d  <= vga_in.vsync;
      vblnk_d  <= vga_in.vblnk;
      hcount_d <= vga_in.hcount;
      hsync_d  <= vga_in.hsync;
      hblnk_d  <= vga_in.hblnk;
      rgb_d    <= vga_in.rgb;
    end
  end

  // rom_data here answers the address registered on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vcount_d;
      vga_out.vsync  <= vsync_d;
      vga_out.vblnk  <= vblnk_d;
      vga_out.hcount <= hcount_d;
      vga_out.hsync  <= hsync_d;
      vga_out.hblnk  <= hblnk_d;
      vga_out.rgb    <= (in_box_d && rom_data != TRANSPARENT) ? rom_data : rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: table of single pixels plus hand sequences for
// double buffering, coincident update, latency alignment and mid-line reset.
module tb_draw_sprite;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [10:0]       xpos_in, ypos_in;
  logic              pos_valid;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic [11:0]       rom_fill;

  vga_if vin ();
  vga_if vout ();

  draw_sprite dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vin),
    .vga_out   (vout),
    .xpos_in   (xpos_in),
    .ypos_in   (ypos_in),
    .pos_valid (pos_valid),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  always #5 clk = ~clk;

  // ROM stand-in: a uniform fill held by the bench for the pixel under test.
  assign rom_data = rom_fill;

  int tests = 0;
  int fails = 0;
  logic [37:0] exp_q[$];

  typedef struct {
    logic [10:0] px, py, hc, vc;
    logic        hb, vb;
    logic [11:0] rgb, fill, exp_addr, exp_rgb;
  } vec_t;

  vec_t vecs[16];
  logic [10:0] cur_x, cur_y;

  function automatic logic [37:0] pack(logic [10:0] vc, logic vs, logic vb,
                                       logic [10:0] hc, logic hs, logic hb, logic [11:0] c);
    return {vc, vs, vb, hc, hs, hb, c};
  endfunction

  function automatic logic [37:0] out_pack();
    return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
  endfunction

  task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hb,
                       input logic vb, input logic [11:0] c);
    vin.hcount = hc;
    vin.vcount = vc;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hc[0];
    vin.vsync  = vc[1];
    vin.rgb    = c;
  endtask

  task automatic idle();
    drive(11'd0, 11'd0, 1'b1, 1'b0, 12'h000);
    pos_valid = 1'b0;
  endtask

  task automatic apply(input string name, input vec_t v);
    drive(v.hc, v.vc, v.hb, v.vb, v.rgb);
    rom_fill = v.fill;
    tick();
    check({name, "_addr"}, 38'(rom_addr), 38'(v.exp_addr));
    idle();
    tick();
    check({name, "_out"}, out_pack(), pack(v.vc, v.vc[1], v.vb, v.hc, v.hc[0], v.hb, v.exp_rgb));
  endtask

  task automatic check_pixel(input string name, input logic [10:0] hc, input logic [10:0] vc,
                             input logic [11:0] fill, input logic [11:0] ea, input logic [11:0] er);
    vec_t v;
    v = '{cur_x, cur_y, hc, vc, 1'b0, 1'b0, 12'h111, fill, ea, er};
    apply(name, v);
  endtask

  task automatic vblank_rise();
    idle();
    vin.vblnk = 1'b1;
    tick();
    idle();
    tick();
  endtask

  task automatic set_pos(input logic [10:0] x, input logic [10:0] y);
    idle();
    pos_valid = 1'b1;
    xpos_in   = x;
    ypos_in   = y;
    tick();
    pos_valid = 1'b0;
    vblank_rise();
    cur_x = x;
    cur_y = y;
  endtask

  initial begin
    //          px     py     hc     vc    hb  vb  rgb     fill    addr   rgb_out
    vecs[0]  = '{11'd0, 11'd0, 11'd5, 11'd5, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd245, 12'h00F};
    vecs[1]  = '{11'd0, 11'd0, 11'd48, 11'd5, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd0, 12'h111};
    vecs[2]  = '{11'd0, 11'd0, 11'd47, 11'd63, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd3071, 12'h00F};
    vecs[3]  = '{11'd0, 11'd0, 11'd47, 11'd64, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd0, 12'h111};
    vecs[4]  = '{11'd0, 11'd0, 11'd900, 11'd5, 1'b1, 1'b0, 12'h000, 12'h00F, 12'd0, 12'h000};
    vecs[5]  = '{11'd100, 11'd200, 11'd110, 11'd203, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd154, 12'h00F};
    vecs[6]  = '{11'd100, 11'd200, 11'd99, 11'd203, 1'b0, 1'b0, 12'h111, 12'h00F, 12'd0, 12'h111};
    vecs[7]  = '{11'd100, 11'd200, 11'd110, 11'd203, 1'b0, 1'b0, 12'h111, 12'hF0F, 12'd154, 12'h111};
    vecs[8]  = '{11'd100, 11'd200, 11'd110, 11'd203, 1'b0, 1'b0, 12'h111, 12'hFF0, 12'd154, 12'hFF0};
    vecs[9]  = '{11'd100, 11'd200, 11'd147, 11'd263, 1'b0, 1'b0, 12'h111, 12'h0A5, 12'd3071, 12'h0A5};
    vecs[10] = '{11'd100, 11'd200, 11'd148, 11'd200, 1'b0, 1'b0, 12'h111, 12'h0A5, 12'd0, 12'h111};
    vecs[11] = '{11'd100, 11'd200, 11'd100, 11'd199, 1'b0, 1'b0, 12'h111, 12'h0A5, 12'd0, 12'h111};
    vecs[12] = '{11'd780, 11'd580, 11'd799, 11'd599, 1'b0, 1'b0, 12'h111, 12'h0F0, 12'd931, 12'h0F0};
    vecs[13] = '{11'd780, 11'd580, 11'd800, 11'd599, 1'b1, 1'b0, 12'h000, 12'h0F0, 12'd0, 12'h000};
    vecs[14] = '{11'd780, 11'd580, 11'd799, 11'd600, 1'b0, 1'b1, 12'h000, 12'h0F0, 12'd0, 12'h000};
    vecs[15] = '{11'd2040, 11'd0, 11'd5, 11'd5, 1'b0, 1'b0, 12'h111, 12'h0F0, 12'd0, 12'h111};

    // Reset with a live in-box pixel on the inputs.
    rst = 1'b1;
    pos_valid = 1'b0;
    xpos_in = 11'd0;
    ypos_in = 11'd0;
    rom_fill = 12'h00F;
    drive(11'd5, 11'd5, 1'b0, 1'b0, 12'h111);
    cur_x = 11'd0;
    cur_y = 11'd0;
    tick();
    check("reset_out", out_pack(), 38'd0);
    check("reset_addr", 38'(rom_addr), 38'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Single-pixel table; position changes go through a vblank edge.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].px != cur_x || vecs[i].py != cur_y)
        set_pos(vecs[i].px, vecs[i].py);
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-frame strobe must not move the sprite until the next vblank edge.
    set_pos(11'd0, 11'd0);
    pos_valid = 1'b1;
    xpos_in = 11'd300;
    ypos_in = 11'd300;
    tick();
    pos_valid = 1'b0;
    check_pixel("dbuf_old_in", 11'd5, 11'd10, 12'h0F0, 12'd485, 12'h0F0);
    check_pixel("dbuf_new_out", 11'd305, 11'd305, 12'h0F0, 12'd0, 12'h111);
    vblank_rise();
    cur_x = 11'd300;
    cur_y = 11'd300;
    check_pixel("dbuf_new_in", 11'd305, 11'd305, 12'h0F0, 12'd245, 12'h0F0);
    check_pixel("dbuf_old_out", 11'd5, 11'd10, 12'h0F0, 12'd0, 12'h111);

    // Strobe coincident with vblank rise applies to the coming frame.
    idle();
    vin.vblnk = 1'b1;
    pos_valid = 1'b1;
    xpos_in = 11'd10;
    ypos_in = 11'd20;
    tick();
    idle();
    tick();
    cur_x = 11'd10;
    cur_y = 11'd20;
    check_pixel("coinc_corner", 11'd10, 11'd20, 12'h0F0, 12'd0, 12'h0F0);
    check_pixel("coinc_old", 11'd305, 11'd305, 12'h0F0, 12'd0, 12'h111);
    vblank_rise();
    check_pixel("coinc_pend", 11'd12, 11'd21, 12'h0F0, 12'd50, 12'h0F0);

    // Blanking stream with random fields: every output is the input two cycles late.
    for (int i = 0; i < 40; i++) begin
      logic [10:0] rh, rv;
      logic [11:0] rc;
      logic        rvb;
      rh  = 11'($urandom_range(0, 2047));
      rv  = 11'($urandom_range(0, 2047));
      rc  = 12'($urandom_range(0, 4095));
      rvb = 1'($urandom_range(0, 1));
      rom_fill = 12'($urandom_range(0, 4094));
      drive(rh, rv, 1'b1, rvb, rc);
      exp_q.push_back(pack(rv, rv[1], rvb, rh, rh[0], 1'b1, rc));
      tick();
      if (exp_q.size() == 2)
        check($sformatf("latency%0d", i), out_pack(), exp_q.pop_front());
    end
    idle();
    tick();
    tick();

    // Reset in the middle of a line drops in-flight pixels and returns act to (0,0).
    rom_fill = 12'h00F;
    drive(11'd15, 11'd25, 1'b0, 1'b0, 12'h111);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out", out_pack(), 38'd0);
    check("midrst_addr", 38'(rom_addr), 38'd0);
    rst = 1'b0;
    idle();
    tick();
    cur_x = 11'd0;
    cur_y = 11'd0;
    check_pixel("post_rst_origin", 11'd5, 11'd5, 12'h00F, 12'd245, 12'h00F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
